seq_mag_comp: RTL and testbench

//  Parametrised multi-cycle magnitude comparator: successor of the 4-bit combinational comparator.

---
 rtl/seq_comp_pkg.sv | 22 ++
 rtl/comp_slice.sv | 30 +++
 rtl/seq_mag_comp.sv | 144 ++++++++++++++
 tb/tb_seq_mag_comp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_comp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
`timescale 1ns/1ps
package seq_comp_pkg;

    // Controller states: waiting for a request, or walking slices MSB-first.
    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // One-hot result encoding, packed as {grt, sma, eq}; all-zero means no result yet.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GRT  = 3'b100;
    localparam logic [2:0] RES_SMA  = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

    // Width of the slice index; at least one bit so a single-slice build still has a register.
    function automatic int idx_width(input int nsl);
        return (nsl > 1) ? $clog2(nsl) : 1;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// Combinational CHUNK-bit magnitude compare of one operand slice.
// With invert_msb set, the slice MSB of both inputs is flipped, which turns an
// unsigned compare of the top slice into a two's-complement compare.
`timescale 1ns/1ps
module comp_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             invert_msb,
    output logic             gt,
    output logic             lt
);

    logic [CHUNK-1:0] x_m;
    logic [CHUNK-1:0] y_m;

    // Optionally flip the sign bit of both slices before the unsigned compare.
    always_comb begin
        // NOTE: every combinational output gets a full default first, so no path leaves it unassigned and no latch is inferred.
        x_m = x;
        y_m = y;
        x_m[CHUNK-1] = x[CHUNK-1] ^ invert_msb;
        y_m[CHUNK-1] = y[CHUNK-1] ^ invert_msb;
    end

    assign gt = (x_m > y_m);
    assign lt = (x_m < y_m);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: compares W-bit operands MSB-first, CHUNK
// bits per cycle, signed or unsigned, stopping at the first differing slice.
// Optional feature macro: SEQ_COMP_STATS_EN adds saturating result counters
// cnt_grt / cnt_sma / cnt_eq.
`timescale 1ns/1ps
module seq_mag_comp
    import seq_comp_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic             grt,
    output logic             sma,
    output logic             eq
`ifdef SEQ_COMP_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_grt,
    output logic [CNT_W-1:0] cnt_sma,
    output logic [CNT_W-1:0] cnt_eq
`endif
);

    localparam int NSL   = W / CHUNK;
    localparam int IDX_W = idx_width(NSL);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NSL - 1);

    // Reject configurations that cannot be split into whole slices.
    if ((W % CHUNK) != 0 || CHUNK < 1 || CNT_W < 1) begin : g_bad_params
        $error("seq_mag_comp: W must be a positive multiple of CHUNK and CNT_W >= 1");
    end

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [W-1:0]     a_q, b_q;
    logic             signed_q;
    logic [2:0]       res_q, res_next;
    logic             capture, finish;
    logic [CHUNK-1:0] slice_a, slice_b;
    logic             invert_msb, slice_gt, slice_lt;

    // Slice mux: the captured operands are presented one slice at a time.
    assign slice_a    = a_q[idx*CHUNK +: CHUNK];
    assign slice_b    = b_q[idx*CHUNK +: CHUNK];
    assign invert_msb = signed_q && (idx == TOP_IDX);

    comp_slice #(.CHUNK(CHUNK)) u_slice (
        .x          (slice_a),
        .y          (slice_b),
        .invert_msb (invert_msb),
        .gt         (slice_gt),
        .lt         (slice_lt)
    );

    // Next-state, index and result decode for the IDLE/CMP controller.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        finish     = 1'b0;
        res_next   = RES_EQ;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    idx_next   = TOP_IDX;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (slice_gt) begin
                    res_next   = RES_GRT;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (slice_lt) begin
                    res_next   = RES_SMA;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (idx == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    idx_next = idx - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller state, slice index, result flags and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            res_q <= RES_NONE;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from pre-edge values, matching real flops.
            state <= state_next;
            idx   <= idx_next;
            done  <= finish;
            if (finish) begin
                res_q <= res_next;
            end
        end
    end

    // Operand capture on an accepted start; later a/b changes are not seen.
    // NOTE: no reset on these data registers: they are always loaded before the controller reads them.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
        end
    end

    assign busy            = (state == CMP);
    assign {grt, sma, eq}  = res_q;

`ifdef SEQ_COMP_STATS_EN
    // Saturating per-result counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_grt <= '0;
            cnt_sma <= '0;
            cnt_eq  <= '0;
        end else if (finish) begin
            if (res_next == RES_GRT && cnt_grt != '1) cnt_grt <= cnt_grt + 1'b1;
            if (res_next == RES_SMA && cnt_sma != '1) cnt_sma <= cnt_sma + 1'b1;
            if (res_next == RES_EQ  && cnt_eq  != '1) cnt_eq  <= cnt_eq  + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp at W=8, CHUNK=2 (4 slices), CNT_W=4.
// Counter checks are compiled in when SEQ_COMP_STATS_EN is defined.
`timescale 1ns/1ps
module tb_seq_mag_comp;

    localparam int W = 8;
    localparam int CHUNK = 2;
    localparam int NSL = W / CHUNK;
    localparam int CNT_W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a, b;
    logic         busy, done, grt, sma, eq;
`ifdef SEQ_COMP_STATS_EN
    logic [CNT_W-1:0] cnt_grt, cnt_sma, cnt_eq;
`endif

    int checks = 0;
    int errors = 0;

    seq_mag_comp #(.W(W), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .grt         (grt),
        .sma         (sma),
        .eq          (eq)
`ifdef SEQ_COMP_STATS_EN
        ,
        .cnt_grt     (cnt_grt),
        .cnt_sma     (cnt_sma),
        .cnt_eq      (cnt_eq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [2:0]   res;   // {grt, sma, eq}
        int           lat;   // edges from start edge (inclusive) to done visible
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: numeric comparison of the operands as integers.
    function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        int ix, iy;
        ix = sm ? int'($signed(x)) : int'(x);
        iy = sm ? int'($signed(y)) : int'(y);
        if (ix > iy) return 3'b100;
        if (ix < iy) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: slices examined up to the first differing one, plus the start edge.
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int k = 0;
        for (int s = NSL - 1; s >= 0; s--) begin
            k++;
            if (((int'(x) >> (s * CHUNK)) % (1 << CHUNK)) != ((int'(y) >> (s * CHUNK)) % (1 << CHUNK)))
                return k + 1;
        end
        return NSL + 1;
    endfunction

    // Launch one compare, scramble a/b while busy, and wait (bounded) for done.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                           output int lat, output int busy_cnt, output logic [2:0] res);
        @(negedge clk);
        a = ta; b = tb_v; signed_mode = tsm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = ~tsm;
        lat = 1; busy_cnt = 0; res = 3'b000;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (done) res = {grt, sma, eq};
        else lat = -1;
    endtask

    vec_t vecs[10];
    int lat, bcnt, exp_lat, done_seen;
    logic [2:0] res, exp_res;
    logic [W-1:0] ra, rb;
    logic rsm;

    initial begin
        vecs[0] = '{8'h80, 8'h01, 1'b0, 3'b100, 2};
        vecs[1] = '{8'h80, 8'h01, 1'b1, 3'b010, 2};
        vecs[2] = '{8'h5A, 8'h5A, 1'b0, 3'b001, 5};
        vecs[3] = '{8'h5A, 8'h5A, 1'b1, 3'b001, 5};
        vecs[4] = '{8'h12, 8'h13, 1'b0, 3'b010, 5};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 3'b010, 2};
        vecs[6] = '{8'h7F, 8'h80, 1'b1, 3'b100, 2};
        vecs[7] = '{8'h40, 8'h30, 1'b0, 3'b100, 2};
        vecs[8] = '{8'h34, 8'h37, 1'b1, 3'b010, 5};
        vecs[9] = '{8'h12, 8'h1A, 1'b0, 3'b010, 4};

        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_res", {grt, sma, eq}, 3'b000);
`ifdef SEQ_COMP_STATS_EN
        check("reset_cnt", {cnt_grt, cnt_sma, cnt_eq}, 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, lat, bcnt, res);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_busy", i), bcnt, vecs[i].lat - 1);
        end

        // Second start while busy is ignored; start during done is accepted.
        @(negedge clk);
        a = 8'h00; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_done", done, 1);
        check("busy_start_res", {grt, sma, eq}, 3'b010);
        a = 8'hFF; b = 8'h00; start = 1'b1;   // still in the done cycle
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_busy", busy, 1);
        @(posedge clk); #1;
        check("done_start_done", done, 1);
        check("done_start_res", {grt, sma, eq}, 3'b100);
        done_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("no_extra_done", done_seen, 0);

        // Reset mid-compare aborts with no done pulse.
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_res", {grt, sma, eq}, 3'b000);
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle", busy, 0);
        run_cmp(8'h5A, 8'h5A, 1'b0, lat, bcnt, res);
        check("post_abort_lat", lat, 5);
        check("post_abort_res", res, 3'b001);

        // Randomized compares against the reference model.
        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            rb = (n % 4 == 0) ? ra ^ W'(1 << $urandom_range(W - 1, 0)) : W'($urandom);
            if (n % 10 == 0) rb = ra;
            rsm = 1'($urandom);
            exp_res = model_res(ra, rb, rsm);
            exp_lat = model_lat(ra, rb);
            run_cmp(ra, rb, rsm, lat, bcnt, res);
            check($sformatf("rnd%0d_res a=%0h b=%0h s=%0d", n, ra, rb, rsm), res, exp_res);
            check($sformatf("rnd%0d_lat", n), lat, exp_lat);
        end

`ifdef SEQ_COMP_STATS_EN
        // Counter saturation after a fresh reset.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("cnt_cleared", {cnt_grt, cnt_sma, cnt_eq}, 0);
        for (int n = 0; n < 17; n++) begin
            run_cmp(8'h80, 8'h01, 1'b0, lat, bcnt, res);
            if (n == 0) check("cnt_grt_first", cnt_grt, 1);
        end
        check("cnt_grt_sat", cnt_grt, 4'hF);
        check("cnt_sma_zero", cnt_sma, 0);
        check("cnt_eq_zero", cnt_eq, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
